fetch_unit: RTL

//  Instruction fetch stage: drives the instruction-memory address, reads the byte-wide

---
 rtl/cpu_defs_pkg.sv | 14 +
 rtl/fetch_out_reg.sv | 44 ++++
 rtl/fetch_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: vector addresses,
// two-byte opcode marker and fetch FSM encoding.
package cpu_defs;

  localparam logic [7:0] RESET_VEC_ADDR = 8'h00;
  localparam logic [7:0] INT_VEC_ADDR   = 8'h01;
  localparam logic [3:0] IMM_OPCODE     = 4'hC;

  localparam logic [1:0] ST_RST_VEC = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_IMM     = 2'd2;
  localparam logic [1:0] ST_INT_VEC = 2'd3;

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready holding register between fetch and decode.
// Load wins over drain; flush drops the entry.
module fetch_out_reg #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          flush,
  input  logic          ready,
  input  logic [DW-1:0] in_instr,
  input  logic [DW-1:0] in_imm,
  input  logic          in_has_imm,
  input  logic [AW-1:0] in_pc,
  output logic          valid,
  output logic [DW-1:0] instr,
  output logic [DW-1:0] imm,
  output logic          has_imm,
  output logic [AW-1:0] pc
);

  // hold, load, flush or drain the decode entry
  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      instr   <= '0;
      imm     <= '0;
      has_imm <= 1'b0;
      pc      <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      instr   <= in_instr;
      imm     <= in_imm;
      has_imm <= in_has_imm;
      pc      <= in_pc;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, handles reset and
// interrupt vectors, redirects and two-byte instructions.
module fetch_unit
  import cpu_defs::*;
#(
  parameter int         AW     = 8,
  parameter int         DW     = 8,
  parameter logic [3:0] IMM_OP = IMM_OPCODE
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_instr,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          intr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_instr,
  output logic [DW-1:0] out_imm,
  output logic          out_has_imm,
  output logic [AW-1:0] out_pc,
  output logic          int_ack,
  output logic [AW-1:0] int_ret_pc
);

  logic [1:0]    state;
  logic [AW-1:0] pc;
  logic [AW-1:0] opc_pc;
  logic [DW-1:0] op_buf;
  logic          int_pend;

  logic          accept;
  logic          go;
  logic          is_imm;
  logic          redir;
  logic          load;
  logic [DW-1:0] ld_instr;
  logic [DW-1:0] ld_imm;
  logic          ld_has;
  logic [AW-1:0] ld_pc;

  assign accept = !out_valid || out_ready;
  assign go     = !stall && accept;
  assign is_imm = imem_instr[DW-1 -: 4] == IMM_OP;
  assign redir  = redirect_valid && (state != ST_RST_VEC);

  // address mux: vectors in their states, PC otherwise
  always_comb begin
    imem_addr = pc;
    unique case (1'b1)
      state == ST_RST_VEC: imem_addr = AW'(RESET_VEC_ADDR);
      state == ST_INT_VEC: imem_addr = AW'(INT_VEC_ADDR);
      default:             imem_addr = pc;
    endcase
  end

  // decide whether and what to push into the decode register
  always_comb begin
    load     = 1'b0;
    ld_instr = imem_instr;
    ld_imm   = '0;
    ld_has   = 1'b0;
    ld_pc    = pc;
    if (!redir && go) begin
      unique case (1'b1)
        state == ST_FETCH: load = !int_pend && !is_imm;
        state == ST_IMM: begin
          load     = 1'b1;
          ld_instr = op_buf;
          ld_imm   = imem_instr;
          ld_has   = 1'b1;
          ld_pc    = opc_pc;
        end
        default: load = 1'b0;
      endcase
    end
  end

  // PC, FSM, pending interrupt and opcode buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RST_VEC;
      pc         <= '0;
      opc_pc     <= '0;
      op_buf     <= '0;
      int_pend   <= 1'b0;
      int_ack    <= 1'b0;
      int_ret_pc <= '0;
    end else begin
      int_ack <= 1'b0;
      if (state != ST_RST_VEC && intr)
        int_pend <= 1'b1;
      if (state == ST_RST_VEC) begin
        pc    <= AW'(imem_instr);
        state <= ST_FETCH;
      end else if (redirect_valid) begin
        pc    <= redirect_pc;
        state <= ST_FETCH;
      end else begin
        unique case (1'b1)
          state == ST_INT_VEC: begin
            int_ret_pc <= pc;
            pc         <= AW'(imem_instr);
            int_ack    <= 1'b1;
            int_pend   <= intr;
            state      <= ST_FETCH;
          end
          state == ST_IMM: begin
            if (go) begin
              pc    <= pc + 1'b1;
              state <= ST_FETCH;
            end
          end
          default: begin
            if (go) begin
              if (int_pend) begin
                state <= ST_INT_VEC;
              end else if (is_imm) begin
                op_buf <= imem_instr;
                opc_pc <= pc;
                pc     <= pc + 1'b1;
                state  <= ST_IMM;
              end else begin
                pc <= pc + 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  fetch_out_reg #(
    .AW(AW),
    .DW(DW)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .flush     (redir),
    .ready     (out_ready),
    .in_instr  (ld_instr),
    .in_imm    (ld_imm),
    .in_has_imm(ld_has),
    .in_pc     (ld_pc),
    .valid     (out_valid),
    .instr     (out_instr),
    .imm       (out_imm),
    .has_imm   (out_has_imm),
    .pc        (out_pc)
  );

endmodule
